// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain: parametrised valid/allowin pipeline control with a payload
// register per stage. Stage 0 is the youngest (fetch side) and stage STAGES-1
// the oldest (retire side). Optional performance counters are enabled by
// defining PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl_chain #(
    parameter int unsigned STAGES = 5,
    parameter int unsigned WIDTH  = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_allowin,
    input  logic [STAGES-1:0]         ready_go,
    input  logic [STAGES-1:0]         flush,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
`ifdef PIPE_CTRL_PERF_CNT_EN
    input  logic                      out_allowin,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               retire_cnt
`else
    input  logic                      out_allowin
`endif
);

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];

    logic [STAGES:0]   allowin_c;
    logic [STAGES-1:0] to_next_c;
    logic [STAGES-1:0] kill_c;
    logic              any_flush_c;

    // Backward allowin chain and per-stage kill (any older stage flushing).
    always_comb begin
        logic allow_acc;
        logic kill_acc;
        allowin_c  = '0;
        kill_c     = '0;
        allow_acc  = out_allowin;
        allowin_c[STAGES] = out_allowin;
        for (int i = STAGES - 1; i >= 0; i--) begin
            allow_acc    = !valid_q[i] || (ready_go[i] && allow_acc);
            allowin_c[i] = allow_acc;
        end
        kill_acc = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            kill_c[i] = kill_acc;
            kill_acc  = kill_acc | flush[i];
        end
    end

    assign to_next_c   = valid_q & ready_go;
    assign any_flush_c = |flush;

    assign in_allowin  = allowin_c[0];
    assign out_valid   = to_next_c[STAGES-1];
    assign out_data    = data_q[STAGES-1];
    assign stage_valid = valid_q;

    // Flatten the payload registers onto the stage_data bus.
    for (genvar g = 0; g < STAGES; g++) begin : g_flat
        assign stage_data[g*WIDTH +: WIDTH] = data_q[g];
    end

    // Stage valid/payload registers; a flush clears younger stages and
    // drops the producer offer, taking priority over any load.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            if (kill_c[0]) begin
                valid_q[0] <= 1'b0;
            end else if (allowin_c[0]) begin
                valid_q[0] <= in_valid && !any_flush_c;
            end
            if (in_valid && allowin_c[0] && !any_flush_c) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (kill_c[i]) begin
                    valid_q[i] <= 1'b0;
                end else if (allowin_c[i]) begin
                    valid_q[i] <= to_next_c[i-1];
                end
                if (to_next_c[i-1] && allowin_c[i] && !kill_c[i]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    // Blocked-offer and retirement counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (in_valid && !in_allowin) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (out_valid && out_allowin) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed, table-driven bench for pipe_ctrl_chain (STAGES=5, WIDTH=16).
module tb_pipe_ctrl_chain;

    localparam int unsigned STAGES = 5;
    localparam int unsigned WIDTH  = 16;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic [WIDTH-1:0]        in_data;
    logic                    in_allowin;
    logic [STAGES-1:0]       ready_go;
    logic [STAGES-1:0]       flush;
    logic [STAGES-1:0]       stage_valid;
    logic [STAGES*WIDTH-1:0] stage_data;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic                    out_allowin;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0]             stall_cnt;
    logic [31:0]             retire_cnt;
`endif

    pipe_ctrl_chain #(.STAGES(STAGES), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_allowin  (in_allowin),
        .ready_go    (ready_go),
        .flush       (flush),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
`ifdef PIPE_CTRL_PERF_CNT_EN
        .out_allowin (out_allowin),
        .stall_cnt   (stall_cnt),
        .retire_cnt  (retire_cnt)
`else
        .out_allowin (out_allowin)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic [4:0]  rg;
        logic [4:0]  fl;
        logic        oa;
        logic        ia;
        logic        ov;
        logic [15:0] od;
        logic [4:0]  sv;
        logic        chk_sd;
        logic [79:0] sd;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [15:0] d, input logic [4:0] rg,
                       input logic [4:0] fl, input logic oa, input logic ia, input logic ov,
                       input logic [15:0] od, input logic [4:0] sv, input logic c,
                       input logic [79:0] sd);
        vecs.push_back('{iv, d, rg, fl, oa, ia, ov, od, sv, c, sd});
    endtask

    // Drive one cycle's inputs at the falling edge and let them settle.
    task automatic cyc(input logic iv, input logic [15:0] d, input logic [4:0] rg,
                       input logic [4:0] fl, input logic oa, input logic rst);
        @(negedge clk);
        in_valid    = iv;
        in_data     = d;
        ready_go    = rg;
        flush       = fl;
        out_allowin = oa;
        reset       = rst;
        #1;
    endtask

    initial begin
        int acc;
        int got;
        int lat;

        // Stream 1..8, stall stage 2 for three cycles, resume, flush[3], flush[0], multi-flush.
        add(1, 16'd1,  5'h1f, 5'h00, 1, 1, 0, 16'd0,  5'b00000, 0, '0);
        add(1, 16'd2,  5'h1f, 5'h00, 1, 1, 0, 16'd0,  5'b00001, 0, '0);
        add(1, 16'd3,  5'h1f, 5'h00, 1, 1, 0, 16'd0,  5'b00011, 0, '0);
        add(1, 16'd4,  5'h1f, 5'h00, 1, 1, 0, 16'd0,  5'b00111, 0, '0);
        add(1, 16'd5,  5'h1f, 5'h00, 1, 1, 0, 16'd0,  5'b01111, 0, '0);
        add(1, 16'd6,  5'h1f, 5'h00, 1, 1, 1, 16'd1,  5'b11111, 0, '0);
        add(1, 16'd7,  5'h1f, 5'h00, 1, 1, 1, 16'd2,  5'b11111, 0, '0);
        add(1, 16'd8,  5'h1f, 5'h00, 1, 1, 1, 16'd3,  5'b11111, 0, '0);
        add(1, 16'd9,  5'h1b, 5'h00, 1, 0, 1, 16'd4,  5'b11111, 0, '0);
        add(1, 16'd9,  5'h1b, 5'h00, 1, 0, 1, 16'd5,  5'b10111, 0, '0);
        add(1, 16'd9,  5'h1b, 5'h00, 1, 0, 0, 16'd5,  5'b00111, 1,
            {16'd5, 16'd5, 16'd6, 16'd7, 16'd8});
        add(1, 16'd9,  5'h1f, 5'h00, 1, 1, 0, 16'd5,  5'b00111, 0, '0);
        add(1, 16'd10, 5'h1f, 5'h00, 1, 1, 0, 16'd5,  5'b01111, 0, '0);
        add(1, 16'd11, 5'h1f, 5'h00, 1, 1, 1, 16'd6,  5'b11111, 0, '0);
        add(1, 16'd12, 5'h1f, 5'h00, 1, 1, 1, 16'd7,  5'b11111, 0, '0);
        add(1, 16'd13, 5'h1f, 5'h00, 1, 1, 1, 16'd8,  5'b11111, 0, '0);
        add(1, 16'd14, 5'h1f, 5'h00, 1, 1, 1, 16'd9,  5'b11111, 0, '0);
        add(1, 16'd15, 5'h1f, 5'h08, 1, 1, 1, 16'd10, 5'b11111, 1,
            {16'd10, 16'd11, 16'd12, 16'd13, 16'd14});
        add(1, 16'd16, 5'h1f, 5'h00, 1, 1, 1, 16'd11, 5'b11000, 0, '0);
        add(0, 16'd0,  5'h1f, 5'h00, 1, 1, 1, 16'd12, 5'b10001, 0, '0);
        add(0, 16'd0,  5'h1f, 5'h00, 1, 1, 0, 16'd12, 5'b00010, 0, '0);
        add(0, 16'd0,  5'h1f, 5'h00, 1, 1, 0, 16'd12, 5'b00100, 0, '0);
        add(0, 16'd0,  5'h1f, 5'h00, 1, 1, 0, 16'd12, 5'b01000, 0, '0);
        add(0, 16'd0,  5'h1f, 5'h00, 1, 1, 1, 16'd16, 5'b10000, 0, '0);
        add(1, 16'd20, 5'h1f, 5'h01, 1, 1, 0, 16'd16, 5'b00000, 0, '0);
        add(0, 16'd0,  5'h1f, 5'h00, 1, 1, 0, 16'd16, 5'b00000, 0, '0);
        add(1, 16'd21, 5'h1f, 5'h00, 1, 1, 0, 16'd16, 5'b00000, 0, '0);
        add(1, 16'd22, 5'h1f, 5'h00, 1, 1, 0, 16'd16, 5'b00001, 0, '0);
        add(1, 16'd23, 5'h1f, 5'h05, 1, 1, 0, 16'd16, 5'b00011, 0, '0);
        add(0, 16'd0,  5'h1f, 5'h00, 1, 1, 0, 16'd16, 5'b00100, 0, '0);

        // Power-on reset and reset-state checks.
        cyc(0, 16'd0, 5'h1f, 5'h00, 1, 1);
        cyc(0, 16'd0, 5'h1f, 5'h00, 1, 1);
        cyc(0, 16'd0, 5'h1f, 5'h00, 1, 0);
        chk("reset stage_valid", 128'(stage_valid), 128'(0));
        chk("reset stage_data",  128'(stage_data),  128'(0));
        chk("reset out_valid",   128'(out_valid),   128'(0));
        chk("reset out_data",    128'(out_data),    128'(0));
        chk("reset in_allowin",  128'(in_allowin),  128'(1));

        // Table-driven per-cycle vectors.
        foreach (vecs[k]) begin
            cyc(vecs[k].iv, vecs[k].d, vecs[k].rg, vecs[k].fl, vecs[k].oa, 0);
            chk($sformatf("row%0d in_allowin", k),  128'(in_allowin),  128'(vecs[k].ia));
            chk($sformatf("row%0d out_valid", k),   128'(out_valid),   128'(vecs[k].ov));
            chk($sformatf("row%0d out_data", k),    128'(out_data),    128'(vecs[k].od));
            chk($sformatf("row%0d stage_valid", k), 128'(stage_valid), 128'(vecs[k].sv));
            if (vecs[k].chk_sd) begin
                chk($sformatf("row%0d stage_data", k), 128'(stage_data), 128'(vecs[k].sd));
            end
        end

        // Reset mid-stream with a full pipe.
        for (int n = 0; n < 6; n++) begin
            cyc(1, 16'(50 + n), 5'h1f, 5'h00, 1, 0);
        end
        chk("pre-reset full", 128'(stage_valid), 128'(5'b11111));
        cyc(1, 16'd99, 5'h1f, 5'h00, 1, 1);
        cyc(0, 16'd0, 5'h1f, 5'h00, 1, 0);
        chk("midreset stage_valid", 128'(stage_valid), 128'(0));
        chk("midreset out_valid",   128'(out_valid),   128'(0));
        chk("midreset in_allowin",  128'(in_allowin),  128'(1));
        chk("midreset stage_data",  128'(stage_data),  128'(0));
        cyc(1, 16'd77, 5'h1f, 5'h00, 1, 0);
        chk("post-reset accept", 128'(in_allowin), 128'(1));
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            cyc(0, 16'd0, 5'h1f, 5'h00, 1, 0);
            lat++;
            if (out_valid) break;
        end
        chk("post-reset latency", 128'(lat), 128'(5));
        chk("post-reset out_data", 128'(out_data), 128'(77));

        // Back-pressure from empty: exactly five accepted, then release in order.
        cyc(0, 16'd0, 5'h1f, 5'h00, 1, 1);
        cyc(0, 16'd0, 5'h1f, 5'h00, 1, 0);
        acc = 0;
        for (int n = 0; n < 8; n++) begin
            cyc(1, 16'(100 + acc), 5'h1f, 5'h00, 0, 0);
            if (in_allowin) acc++;
        end
        chk("bp accepted", 128'(acc), 128'(5));
        chk("bp in_allowin", 128'(in_allowin), 128'(0));
        chk("bp stage_data", 128'(stage_data),
            128'({16'd100, 16'd101, 16'd102, 16'd103, 16'd104}));
        got = 0;
        for (int n = 0; n < 12; n++) begin
            cyc(0, 16'd0, 5'h1f, 5'h00, 1, 0);
            if (out_valid) begin
                chk($sformatf("bp retire%0d", got), 128'(out_data), 128'(100 + got));
                got++;
            end
        end
        chk("bp retired count", 128'(got), 128'(5));
`ifdef PIPE_CTRL_PERF_CNT_EN
        chk("stall_cnt",  128'(stall_cnt),  128'(3));
        chk("retire_cnt", 128'(retire_cnt), 128'(5));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
